// File: rtl/cam_capture_ctrl.sv
// Frame-level sequencer for the OV7670 capture path: XCLK gating, SCCB wait,
// VSYNC-aligned capture into linear BRAM addresses and a tear-free ping-pong bank pair.
module cam_capture_ctrl #(
  parameter int H_WIDTH        = 320,
  parameter int V_WIDTH        = 240,
  parameter int ADDR_WIDTH     = $clog2(H_WIDTH*V_WIDTH),
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                        i_clk,
  input  logic                        i_n_reset,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_mode,
  input  logic                        i_cfg_done,
  input  logic                        i_vsync,
  input  logic                        i_pix_valid,
  input  logic [$clog2(H_WIDTH):0]    i_h_addr,
  input  logic [$clog2(V_WIDTH):0]    i_v_addr,
  input  logic                        i_rd_frame_start,
  output logic                        o_en_xclk,
  output logic                        o_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_wr_addr,
  output logic                        o_wr_bank,
  output logic                        o_rd_bank,
  output logic                        o_frame_done,
  output logic [15:0]                 o_frame_count,
  output logic                        o_err_overrun,
  output logic                        o_err_timeout,
  output logic [2:0]                  o_state
);

  localparam int HA_W = $clog2(H_WIDTH) + 1;
  localparam int VA_W = $clog2(V_WIDTH) + 1;
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [HA_W-1:0]       H_LIM    = HA_W'(H_WIDTH);
  localparam logic [VA_W-1:0]       V_LIM    = VA_W'(V_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] H_STRIDE = ADDR_WIDTH'(H_WIDTH);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_CFG     = 3'd1,
    ST_WAIT_VS_FALL = 3'd2,
    ST_CAPTURE      = 3'd3,
    ST_FRAME_END    = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic                    vs_d_r;
  logic                    mode_r;
  logic [WD_W-1:0]         wd_r;
  logic                    vs_rise_s;
  logic                    vs_fall_s;
  logic                    in_range_s;
  logic                    wd_active_s;
  logic                    start_ok_s;
  logic                    timeout_s;
  logic                    swap_s;
  logic                    frame_end_s;
  logic                    wr_hit_s;
  logic                    overrun_s;
  logic [ADDR_WIDTH-1:0]   addr_s;

  assign vs_rise_s   = i_vsync & ~vs_d_r;
  assign vs_fall_s   = ~i_vsync & vs_d_r;
  assign in_range_s  = (i_h_addr < H_LIM) && (i_v_addr < V_LIM);
  assign wd_active_s = (state_r == ST_WAIT_VS_FALL) || (state_r == ST_CAPTURE);
  assign addr_s      = ADDR_WIDTH'(i_v_addr) * H_STRIDE + ADDR_WIDTH'(i_h_addr);
  assign o_state     = state_r;

  // State register and VSYNC delay for edge detection
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      state_r <= ST_IDLE;
      vs_d_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      vs_d_r  <= i_vsync;
    end
  end

  // Next-state and per-cycle event decode; stop overrides every other event
  always_comb begin
    state_next_s = state_r;
    start_ok_s   = 1'b0;
    timeout_s    = 1'b0;
    swap_s       = 1'b0;
    frame_end_s  = 1'b0;
    wr_hit_s     = 1'b0;
    overrun_s    = 1'b0;
    if (i_stop) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            start_ok_s   = 1'b1;
            state_next_s = ST_WAIT_CFG;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_WAIT_CFG: begin
          if (i_cfg_done) begin
            state_next_s = ST_WAIT_VS_FALL;
          end else begin
            state_next_s = ST_WAIT_CFG;
          end
        end
        ST_WAIT_VS_FALL: begin
          if (wd_r == WD_LAST) begin
            timeout_s    = 1'b1;
            state_next_s = ST_IDLE;
          end else if (vs_fall_s) begin
            state_next_s = ST_CAPTURE;
          end else begin
            state_next_s = ST_WAIT_VS_FALL;
          end
        end
        ST_CAPTURE: begin
          wr_hit_s  = i_pix_valid & in_range_s;
          overrun_s = i_pix_valid & ~in_range_s;
          if (wd_r == WD_LAST) begin
            timeout_s    = 1'b1;
            state_next_s = ST_IDLE;
          end else if (vs_rise_s) begin
            frame_end_s  = 1'b1;
            state_next_s = ST_FRAME_END;
          end else begin
            state_next_s = ST_CAPTURE;
          end
        end
        ST_FRAME_END: begin
          // Only a display frame start seen while already here may swap banks
          if (i_rd_frame_start) begin
            swap_s       = 1'b1;
            state_next_s = mode_r ? ST_WAIT_VS_FALL : ST_IDLE;
          end else begin
            state_next_s = ST_FRAME_END;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // VSYNC watchdog: runs only while an edge is expected, restarts on any state change
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      wd_r <= '0;
    end else if ((state_next_s != state_r) || !wd_active_s) begin
      wd_r <= '0;
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  // Registered outputs, bank ownership, sticky errors and latched mode
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      o_en_xclk     <= 1'b0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_bank     <= 1'b0;
      o_rd_bank     <= 1'b1;
      o_frame_done  <= 1'b0;
      o_frame_count <= 16'd0;
      o_err_overrun <= 1'b0;
      o_err_timeout <= 1'b0;
      mode_r        <= 1'b0;
    end else begin
      o_en_xclk    <= (state_next_s != ST_IDLE);
      o_wr_en      <= wr_hit_s;
      o_frame_done <= frame_end_s;
      if (wr_hit_s) begin
        o_wr_addr <= addr_s;
      end
      if (frame_end_s) begin
        o_frame_count <= o_frame_count + 16'd1;
      end
      if (swap_s) begin
        o_rd_bank <= o_wr_bank;
        o_wr_bank <= ~o_wr_bank;
      end
      if (start_ok_s) begin
        mode_r        <= i_mode;
        o_err_overrun <= 1'b0;
        o_err_timeout <= 1'b0;
      end else begin
        if (overrun_s) begin
          o_err_overrun <= 1'b1;
        end
        if (timeout_s) begin
          o_err_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl on a reduced 8x4 frame with a 1000-cycle watchdog.
module tb_cam_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int TO = 1000;
  localparam int AW = $clog2(H*V);

  logic          clk = 1'b0;
  logic          i_n_reset = 1'b0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic          i_mode = 1'b0;
  logic          i_cfg_done = 1'b0;
  logic          i_vsync = 1'b1;
  logic          i_pix_valid = 1'b0;
  logic [3:0]    i_h_addr = '0;
  logic [2:0]    i_v_addr = '0;
  logic          i_rd_frame_start = 1'b0;
  logic          o_en_xclk, o_wr_en, o_wr_bank, o_rd_bank, o_frame_done;
  logic          o_err_overrun, o_err_timeout;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_frame_count;
  logic [2:0]    o_state;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt = 0, done_cnt = 0, bank_viol = 0;
  int wr_mark = 0, done_mark = 0;
  int first_addr = -1, last_addr = -1;

  cam_capture_ctrl #(.H_WIDTH(H), .V_WIDTH(V), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_n_reset(i_n_reset), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_cfg_done(i_cfg_done), .i_vsync(i_vsync),
    .i_pix_valid(i_pix_valid), .i_h_addr(i_h_addr), .i_v_addr(i_v_addr),
    .i_rd_frame_start(i_rd_frame_start), .o_en_xclk(o_en_xclk), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
    .o_frame_done(o_frame_done), .o_frame_count(o_frame_count),
    .o_err_overrun(o_err_overrun), .o_err_timeout(o_err_timeout), .o_state(o_state)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (o_wr_en) begin
      if (wr_cnt == wr_mark) first_addr = int'(o_wr_addr);
      last_addr = int'(o_wr_addr);
      wr_cnt++;
    end
    if (o_frame_done) done_cnt++;
    if (o_wr_bank == o_rd_bank) bank_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    wr_mark    = wr_cnt;
    done_mark  = done_cnt;
    first_addr = -1;
    last_addr  = -1;
  endtask

  task automatic do_reset();
    i_n_reset = 1'b0;
    i_start = 1'b0; i_stop = 1'b0; i_pix_valid = 1'b0; i_rd_frame_start = 1'b0;
    step();
    i_n_reset = 1'b1;
    step();
  endtask

  task automatic pixel(input int h, input int v);
    i_pix_valid = 1'b1;
    i_h_addr = 4'(h);
    i_v_addr = 3'(v);
    step();
    i_pix_valid = 1'b0;
    step();
  endtask

  task automatic send_frame(input bit rd_at_rise);
    i_vsync = 1'b1;
    repeat (3) step();
    i_vsync = 1'b0;
    repeat (2) step();
    for (int v = 0; v < V; v++)
      for (int h = 0; h < H; h++)
        pixel(h, v);
    i_vsync = 1'b1;
    i_rd_frame_start = rd_at_rise;
    step();
    i_rd_frame_start = 1'b0;
  endtask

  task automatic swap_pulse();
    i_rd_frame_start = 1'b1;
    step();
    i_rd_frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL tb_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    do_reset();
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_xclk", 32'(o_en_xclk), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_wr_bank", 32'(o_wr_bank), 32'd0);
    check("rst_rd_bank", 32'(o_rd_bank), 32'd1);
    check("rst_count", 32'(o_frame_count), 32'd0);

    // Single-frame capture, cfg_done after 100 cycles
    i_mode = 1'b0; i_start = 1'b1; step(); i_start = 1'b0;
    check("t1_wait_cfg", 32'(o_state), 32'd1);
    check("t1_xclk_on", 32'(o_en_xclk), 32'd1);
    repeat (100) step();
    check("t1_still_cfg", 32'(o_state), 32'd1);
    i_cfg_done = 1'b1; step();
    check("t1_wait_vs", 32'(o_state), 32'd2);
    mark();
    send_frame(1'b0);
    check("t1_frame_end", 32'(o_state), 32'd4);
    check("t1_done_pulse", 32'(o_frame_done), 32'd1);
    check("t1_count", 32'(o_frame_count), 32'd1);
    step();
    check("t1_done_one_cycle", 32'(o_frame_done), 32'd0);
    repeat (5) step();
    check("t1_writes", 32'(wr_cnt - wr_mark), 32'(H*V));
    check("t1_first_addr", 32'(first_addr), 32'd0);
    check("t1_last_addr", 32'(last_addr), 32'(H*V - 1));
    check("t1_done_cnt", 32'(done_cnt - done_mark), 32'd1);
    check("t1_hold_frame_end", 32'(o_state), 32'd4);
    swap_pulse();
    check("t1_wr_bank", 32'(o_wr_bank), 32'd1);
    check("t1_rd_bank", 32'(o_rd_bank), 32'd0);
    check("t1_idle", 32'(o_state), 32'd0);
    check("t1_xclk_off", 32'(o_en_xclk), 32'd0);

    // Start with VS low mid-frame; coincident rd_frame_start at frame end is ignored
    i_vsync = 1'b0; repeat (3) step();
    i_start = 1'b1; step(); i_start = 1'b0; step();
    check("t2_wait_vs", 32'(o_state), 32'd2);
    mark();
    pixel(3, 2); pixel(4, 2); pixel(5, 2);
    check("t2_partial_no_wr", 32'(wr_cnt - wr_mark), 32'd0);
    send_frame(1'b1);
    check("t2_frame_end", 32'(o_state), 32'd4);
    check("t2_no_early_swap", 32'(o_wr_bank), 32'd1);
    repeat (3) step();
    check("t2_first_addr", 32'(first_addr), 32'd0);
    check("t2_writes", 32'(wr_cnt - wr_mark), 32'(H*V));
    check("t2_count", 32'(o_frame_count), 32'd2);
    swap_pulse();
    check("t2_wr_bank", 32'(o_wr_bank), 32'd0);
    check("t2_rd_bank", 32'(o_rd_bank), 32'd1);

    // Continuous mode, three frames with a swap each
    do_reset();
    i_mode = 1'b1; i_start = 1'b1; step(); i_start = 1'b0; i_mode = 1'b0; step();
    i_start = 1'b1; step(); i_start = 1'b0;
    check("t3_start_ignored", 32'(o_state), 32'd2);
    mark();
    for (int f = 0; f < 3; f++) begin
      send_frame(1'b0);
      step();
      swap_pulse();
      check("t3_back_to_wait_vs", 32'(o_state), 32'd2);
      check("t3_wr_bank", 32'(o_wr_bank), 32'((f + 1) % 2));
      check("t3_rd_bank", 32'(o_rd_bank), 32'(f % 2));
    end
    step();
    check("t3_count", 32'(o_frame_count), 32'd3);
    check("t3_writes", 32'(wr_cnt - wr_mark), 32'(3*H*V));
    check("t3_done_cnt", 32'(done_cnt - done_mark), 32'd3);
    check("t3_bank_distinct", 32'(bank_viol), 32'd0);
    i_stop = 1'b1; step(); i_stop = 1'b0;
    check("t3_stop_idle", 32'(o_state), 32'd0);

    // Out-of-range strobes, then watchdog expiry in WAIT_VS_FALL
    i_start = 1'b1; step(); i_start = 1'b0; step();
    i_vsync = 1'b0; step();
    check("t4_capture", 32'(o_state), 32'd3);
    pixel(H, 1);
    check("t4_oor_h_no_wr", 32'(wr_cnt - wr_mark), 32'(3*H*V));
    check("t4_overrun", 32'(o_err_overrun), 32'd1);
    i_pix_valid = 1'b1; i_h_addr = 4'd0; i_v_addr = 3'(V); step(); i_pix_valid = 1'b0;
    check("t4_oor_v_wr_en", 32'(o_wr_en), 32'd0);
    i_pix_valid = 1'b1; i_h_addr = 4'(H - 1); i_v_addr = 3'(V - 1); step(); i_pix_valid = 1'b0;
    check("t4_corner_wr_en", 32'(o_wr_en), 32'd1);
    check("t4_corner_addr", 32'(o_wr_addr), 32'(H*V - 1));
    i_stop = 1'b1; step(); i_stop = 1'b0;
    check("t4_stop_idle", 32'(o_state), 32'd0);
    check("t4_stop_no_wr", 32'(o_wr_en), 32'd0);
    check("t4_overrun_sticky", 32'(o_err_overrun), 32'd1);
    mark();
    i_start = 1'b1; step(); i_start = 1'b0;
    check("t4_overrun_cleared", 32'(o_err_overrun), 32'd0);
    step();
    check("t5_wd_wait_vs", 32'(o_state), 32'd2);
    repeat (TO - 1) step();
    check("t5_wd_before", 32'(o_state), 32'd2);
    check("t5_wd_no_err_yet", 32'(o_err_timeout), 32'd0);
    step();
    check("t5_wd_idle", 32'(o_state), 32'd0);
    check("t5_wd_err", 32'(o_err_timeout), 32'd1);
    check("t5_wd_xclk_off", 32'(o_en_xclk), 32'd0);
    check("t5_wd_no_done", 32'(done_cnt - done_mark), 32'd0);

    // Stop mid-capture, then async reset in FRAME_END
    do_reset();
    i_start = 1'b1; i_stop = 1'b1; step(); i_start = 1'b0; i_stop = 1'b0;
    check("t6_start_stop_idle", 32'(o_state), 32'd0);
    i_start = 1'b1; step(); i_start = 1'b0; step();
    i_vsync = 1'b1; step(); i_vsync = 1'b0; step();
    check("t6_capture", 32'(o_state), 32'd3);
    mark();
    i_pix_valid = 1'b1; i_h_addr = 4'd1; i_v_addr = 3'd0; i_stop = 1'b1; step();
    i_pix_valid = 1'b0; i_stop = 1'b0;
    check("t6_stop_idle", 32'(o_state), 32'd0);
    check("t6_stop_no_wr", 32'(o_wr_en), 32'd0);
    step();
    check("t6_stop_no_done", 32'(done_cnt - done_mark), 32'd0);
    check("t6_stop_count", 32'(o_frame_count), 32'd0);
    i_start = 1'b1; step(); i_start = 1'b0; step();
    send_frame(1'b0);
    check("t6_frame_end", 32'(o_state), 32'd4);
    check("t6_count", 32'(o_frame_count), 32'd1);
    #2 i_n_reset = 1'b0;
    #1;
    check("t6_arst_state", 32'(o_state), 32'd0);
    check("t6_arst_count", 32'(o_frame_count), 32'd0);
    check("t6_arst_rd_bank", 32'(o_rd_bank), 32'd1);
    check("t6_arst_wr_bank", 32'(o_wr_bank), 32'd0);
    check("t6_arst_done", 32'(o_frame_done), 32'd0);
    step();
    i_n_reset = 1'b1;
    step();
    swap_pulse();
    check("t6_swap_lost_wr", 32'(o_wr_bank), 32'd0);
    check("t6_swap_lost_rd", 32'(o_rd_bank), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-level sequencer for the OV7670 capture path. It gates the camera XCLK, waits for SCCB configuration, and aligns capture to a VSYNC frame boundary. It converts the receiver's pixel strobes and h/v addresses into linear BRAM write requests and runs a ping-pong BRAM bank pair shared between the camera writer and the VGA reader. Bank swaps happen only at a display frame start, so the display never tears.

Parameters:
H_WIDTH, 320, active pixels per line
V_WIDTH, 240, active lines per frame
ADDR_WIDTH, $clog2(H_WIDTH*V_WIDTH) = 17, linear BRAM address width
TIMEOUT_CYCLES, 2_500_000, i_clk cycles without the expected VSYNC edge before abort

Ports:
i_clk  in  1  system clock
i_n_reset  in  1  asynchronous, active-low reset
i_start  in  1  start request, level-sampled, honoured only in IDLE
i_stop  in  1  abort request, any state
i_mode  in  1  0 = single frame, 1 = continuous; sampled on start
i_cfg_done  in  1  SCCB register load complete (level)
i_vsync  in  1  synchronized VS from receiver (high = vertical blanking)
i_pix_valid  in  1  single-cycle pixel strobe from receiver
i_h_addr  in  $clog2(H_WIDTH)+1  receiver column
i_v_addr  in  $clog2(V_WIDTH)+1  receiver row
i_rd_frame_start  in  1  single-cycle pulse from VGA reader at display frame start
o_en_xclk  out  1  XCLK generator enable
o_wr_en  out  1  BRAM write strobe
o_wr_addr  out  ADDR_WIDTH  linear write address
o_wr_bank  out  1  bank currently owned by writer
o_rd_bank  out  1  bank currently owned by reader
o_frame_done  out  1  one-cycle pulse per completed frame
o_frame_count  out  16  completed frames, wraps 0xFFFF->0
o_err_overrun  out  1  sticky: out-of-range pixel dropped
o_err_timeout  out  1  sticky: VSYNC watchdog expired
o_state  out  3  IDLE=0, WAIT_CFG=1, WAIT_VS_FALL=2, CAPTURE=3, FRAME_END=4

Behaviour:
- Reset values:
  - state IDLE; all outputs 0, except o_rd_bank=1 (so o_wr_bank=0 and o_rd_bank=1); watchdog 0.
- VSYNC edges: vs_d registers i_vsync; rise = i_vsync & ~vs_d; fall = ~i_vsync & vs_d.
- IDLE:
  - o_en_xclk=0.
  - On i_start: clear both sticky errors, latch mode -> WAIT_CFG.
- WAIT_CFG:
  - o_en_xclk=1; XCLK is needed for SCCB.
  - When i_cfg_done=1 -> WAIT_VS_FALL on the next cycle (1-cycle stay minimum).
- WAIT_VS_FALL:
  - On fall -> CAPTURE and reset watchdog.
  - Entry with VS low mid-frame waits for the following fall, so no partial frame is captured.
- CAPTURE:
  - On i_pix_valid with i_h_addr<H_WIDTH and i_v_addr<V_WIDTH: next cycle o_wr_en=1 and o_wr_addr=i_v_addr*H_WIDTH+i_h_addr (1-cycle latency, registered).
  - Out-of-range strobe: no write, set o_err_overrun.
  - On rise -> FRAME_END; o_frame_done=1 for exactly that transition cycle; o_frame_count+1.
- FRAME_END:
  - No writes.
  - On i_rd_frame_start: o_rd_bank<=o_wr_bank, o_wr_bank<=~o_wr_bank; then -> WAIT_VS_FALL if continuous, else IDLE.
  - A rd_frame_start coincident with the CAPTURE->FRAME_END transition is not used; the swap waits for the next pulse.
  - Camera frames arriving during FRAME_END are skipped.
- o_wr_bank != o_rd_bank at all times.
- Watchdog:
  - Counts in WAIT_VS_FALL and CAPTURE; cleared on every state change.
  - Reaching TIMEOUT_CYCLES-1: set o_err_timeout, go IDLE, no frame_done, banks unchanged.
- i_stop (priority over all other events): next state IDLE, o_wr_en=0 next cycle, banks and count unchanged, errors kept.
- i_start outside IDLE ignored; i_start and i_stop together in IDLE -> stays IDLE.
- Async reset mid-frame: immediate return to reset values; a pending swap is lost.
- Sticky errors clear only on accepted start or reset.

Test Plan:
- Single-mode start, cfg_done after 100 cycles, 320x240 frame: 76800 o_wr_en pulses, last o_wr_addr=76799, one o_frame_done, count=1; swap on next rd_frame_start gives wr_bank=1, rd_bank=0; state returns to 0.
- Start with VS low mid-frame: no writes until after the next VS fall; the first write has addr 0.
- Continuous mode, 3 frames, rd_frame_start each frame: count=3; bank toggles every swap; wr_bank never equals rd_bank.
- Pixel strobe with h=320, v=5: no o_wr_en; o_err_overrun=1 and holds until the next start.
- VS held constant after start with TIMEOUT_CYCLES=1000: o_err_timeout=1 at cycle 1000 of WAIT_VS_FALL; state 0; o_en_xclk=0.
- i_stop mid-CAPTURE, then async reset mid-FRAME_END: IDLE next cycle with no frame_done; after reset all outputs at reset values, rd_bank=1.
